// File: rtl/bringup_pkg.sv
// bringup_pkg: shared types and constants for the camera-to-monitor power-up
// sequencer.
//   state_e      - sequencer state encoding
//   RETRY_W      - width of the timeout retry counter
//   DEF_*        - default cycle counts and widths for bringup_seq
//   ctl_out_t    - level outputs decoded from a state
//   decode_state - Moore decode of the level outputs for a given state
package bringup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_SDRAM_WAIT = 3'd1,
    ST_CAM_PWR    = 3'd2,
    ST_CAM_CFG    = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_RUN        = 3'd5,
    ST_FAULT      = 3'd6
  } state_e;

  localparam int RETRY_W = 2;

  localparam int DEF_SETTLE_CYC   = 100;
  localparam int DEF_CAM_PWDN_CYC = 1000;
  localparam int DEF_TIMEOUT_CYC  = 2000000;
  localparam int DEF_MAX_RETRY    = 3;
  localparam int DEF_CNT_W        = 24;

  typedef struct packed {
    logic sdram_rst;
    logic cam_pwdn;
    logic video_en;
    logic seq_busy;
    logic seq_fault;
  } ctl_out_t;

  // Level outputs as a pure function of the state; unknown codes fall back
  // to the reset values.
  function automatic ctl_out_t decode_state(input state_e st);
    ctl_out_t o;
    case (st)
      ST_RESET_HOLD: o = '{sdram_rst: 1'b1, cam_pwdn: 1'b1, video_en: 1'b0, seq_busy: 1'b1, seq_fault: 1'b0};
      ST_SDRAM_WAIT: o = '{sdram_rst: 1'b0, cam_pwdn: 1'b1, video_en: 1'b0, seq_busy: 1'b1, seq_fault: 1'b0};
      ST_CAM_PWR,
      ST_CAM_CFG,
      ST_SETTLE:     o = '{sdram_rst: 1'b0, cam_pwdn: 1'b0, video_en: 1'b0, seq_busy: 1'b1, seq_fault: 1'b0};
      ST_RUN:        o = '{sdram_rst: 1'b0, cam_pwdn: 1'b0, video_en: 1'b1, seq_busy: 1'b0, seq_fault: 1'b0};
      ST_FAULT:      o = '{sdram_rst: 1'b1, cam_pwdn: 1'b1, video_en: 1'b0, seq_busy: 1'b0, seq_fault: 1'b1};
      default:       o = '{sdram_rst: 1'b1, cam_pwdn: 1'b1, video_en: 1'b0, seq_busy: 1'b1, seq_fault: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bringup_seq_if.sv
// bringup_seq_if: handshake bundle between the power-up sequencer and the
// blocks it controls.
//   master modport - the sequencer: samples restart / done levels, drives
//                    resets, enables and status
//   slave modport  - the surrounding pipeline (SDRAM ctrl, SCCB, VGA)
interface bringup_seq_if;
  import bringup_pkg::*;

  logic               restart;
  logic               sdram_init_done;
  logic               cam_cfg_done;
  logic               sdram_rst;
  logic               cam_pwdn;
  logic               cam_cfg_start;
  logic               video_en;
  logic               seq_busy;
  logic               seq_fault;
  logic [RETRY_W-1:0] retry_cnt;

  modport master (
    input  restart, sdram_init_done, cam_cfg_done,
    output sdram_rst, cam_pwdn, cam_cfg_start, video_en,
           seq_busy, seq_fault, retry_cnt
  );

  modport slave (
    output restart, sdram_init_done, cam_cfg_done,
    input  sdram_rst, cam_pwdn, cam_cfg_start, video_en,
           seq_busy, seq_fault, retry_cnt
  );
endinterface

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter with a zero flag, shared by all sequencer
// states.
//   clk_100  - clock
//   rst_100  - synchronous active-high reset, counter takes RST_VAL
//   load     - load load_val this cycle (wins over decrement)
//   load_val - value to load
//   zero     - counter currently at zero
// The counter sticks at zero instead of wrapping.
module seq_timer #(
  parameter int               CNT_W   = 24,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk_100,
  input  logic             rst_100,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Counter register: reset, load, or saturating decrement.
  always_ff @(posedge clk_100) begin
    if (rst_100) begin
      cnt_r <= RST_VAL;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/bringup_seq.sv
// bringup_seq: power-up sequencer for the camera-to-monitor pipeline.
//   clk_100 - sole clock
//   rst_100 - synchronous active-high reset
//   bus     - bringup_seq_if.master: restart / sdram_init_done / cam_cfg_done
//             in; sdram_rst, cam_pwdn, cam_cfg_start, video_en, seq_busy,
//             seq_fault, retry_cnt out
// Sequence: RESET_HOLD -> SDRAM_WAIT -> CAM_PWR -> CAM_CFG -> SETTLE -> RUN.
// Compile-time option BRINGUP_TIMEOUT_EN enables the watchdog in SDRAM_WAIT
// and CAM_CFG, retry counting and the FAULT state; without it both wait
// states wait indefinitely and seq_fault / retry_cnt stay 0.
// All outputs are registered and decoded from the next state.
module bringup_seq
  import bringup_pkg::*;
#(
  parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int CAM_PWDN_CYC = DEF_CAM_PWDN_CYC,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int MAX_RETRY    = DEF_MAX_RETRY,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic          clk_100,
  input  logic          rst_100,
  bringup_seq_if.master bus
);

`ifdef BRINGUP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Load values are one less than the dwell time: zero is reached after
  // exactly N cycles in the state.
  localparam logic [CNT_W-1:0] LD_SETTLE  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PWDN    = CNT_W'(CAM_PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_e             state_r, state_nxt_s;
  ctl_out_t           ctl_r, ctl_nxt_s;
  logic               start_r, start_nxt_s;
  logic [RETRY_W-1:0] retry_r, retry_nxt_s, retry_inc_s;
  logic               timeout_s;
  logic               tmr_zero_s, tmr_load_s;
  logic [CNT_W-1:0]   tmr_val_s;

  seq_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_SETTLE)
  ) u_timer (
    .clk_100  (clk_100),
    .rst_100  (rst_100),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // State and output registers.
  always_ff @(posedge clk_100) begin
    if (rst_100) begin
      state_r <= ST_RESET_HOLD;
      ctl_r   <= decode_state(ST_RESET_HOLD);
      start_r <= 1'b0;
      retry_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      ctl_r   <= ctl_nxt_s;
      start_r <= start_nxt_s;
      retry_r <= retry_nxt_s;
    end
  end

  // Next-state logic. Priority: restart, loss of SDRAM init, done level,
  // timer expiry.
  always_comb begin
    state_nxt_s = state_r;
    timeout_s   = 1'b0;
    retry_inc_s = retry_r + {{(RETRY_W-1){1'b0}}, 1'b1};
    if (bus.restart) begin
      state_nxt_s = ST_RESET_HOLD;
    end else begin
      case (state_r)
        ST_RESET_HOLD: begin
          if (tmr_zero_s) state_nxt_s = ST_SDRAM_WAIT;
          else            state_nxt_s = ST_RESET_HOLD;
        end
        ST_SDRAM_WAIT: begin
          if (bus.sdram_init_done)      state_nxt_s = ST_CAM_PWR;
          else if (TO_EN && tmr_zero_s) timeout_s   = 1'b1;
          else                          state_nxt_s = ST_SDRAM_WAIT;
        end
        ST_CAM_PWR: begin
          if (!bus.sdram_init_done) state_nxt_s = ST_RESET_HOLD;
          else if (tmr_zero_s)      state_nxt_s = ST_CAM_CFG;
          else                      state_nxt_s = ST_CAM_PWR;
        end
        ST_CAM_CFG: begin
          if (!bus.sdram_init_done)     state_nxt_s = ST_RESET_HOLD;
          else if (bus.cam_cfg_done)    state_nxt_s = ST_SETTLE;
          else if (TO_EN && tmr_zero_s) timeout_s   = 1'b1;
          else                          state_nxt_s = ST_CAM_CFG;
        end
        ST_SETTLE: begin
          if (!bus.sdram_init_done) state_nxt_s = ST_RESET_HOLD;
          else if (tmr_zero_s)      state_nxt_s = ST_RUN;
          else                      state_nxt_s = ST_SETTLE;
        end
        ST_RUN: begin
          if (!bus.sdram_init_done) state_nxt_s = ST_RESET_HOLD;
          else                      state_nxt_s = ST_RUN;
        end
        ST_FAULT: state_nxt_s = ST_FAULT;
        default:  state_nxt_s = ST_RESET_HOLD;
      endcase
      if (timeout_s) begin
        if (retry_inc_s == RETRY_MAX) state_nxt_s = ST_FAULT;
        else                          state_nxt_s = ST_RESET_HOLD;
      end else begin
        state_nxt_s = state_nxt_s;
      end
    end
    if (bus.restart)    retry_nxt_s = '0;
    else if (timeout_s) retry_nxt_s = retry_inc_s;
    else                retry_nxt_s = retry_r;
  end

  // Output decode from the next state, plus timer reload on every entry
  // (a restart re-enters RESET_HOLD even when already there).
  always_comb begin
    ctl_nxt_s   = decode_state(state_nxt_s);
    start_nxt_s = (state_nxt_s == ST_CAM_CFG) && (state_r != ST_CAM_CFG);
    tmr_load_s  = (state_nxt_s != state_r) || bus.restart;
    case (state_nxt_s)
      ST_RESET_HOLD, ST_SETTLE:  tmr_val_s = LD_SETTLE;
      ST_SDRAM_WAIT, ST_CAM_CFG: tmr_val_s = LD_TIMEOUT;
      ST_CAM_PWR:                tmr_val_s = LD_PWDN;
      default:                   tmr_val_s = '0;
    endcase
  end

  assign bus.sdram_rst     = ctl_r.sdram_rst;
  assign bus.cam_pwdn      = ctl_r.cam_pwdn;
  assign bus.video_en      = ctl_r.video_en;
  assign bus.seq_busy      = ctl_r.seq_busy;
  assign bus.seq_fault     = ctl_r.seq_fault;
  assign bus.cam_cfg_start = start_r;
  assign bus.retry_cnt     = retry_r;

endmodule

// File: doc/bringup_seq.md
# bringup_seq

Power-up sequencer for the camera-to-monitor pipeline, running in the `clk_100` domain after the reset generator's synchronised reset. It releases the SDRAM controller from reset and waits for its init-done. It then powers up the camera, triggers SCCB configuration and waits for completion. After a settle interval it enables the video output path. With the timeout feature compiled in, it retries hung stages and reports a fault.

## Interface
- `SETTLE_CYC`, 100: cycles held in `RESET_HOLD`, and again in `SETTLE` before `video_en`.
- `CAM_PWDN_CYC`, 1000: cycles between camera power-up and the configuration start pulse.
- `TIMEOUT_CYC`, 2000000: watchdog limit for the `SDRAM_WAIT` and `CAM_CFG` states.
- `MAX_RETRY`, 3: number of timeouts allowed before `FAULT`; range 1..3.
- `CNT_W`, 24: counter width; must hold `TIMEOUT_CYC`.
- `clk_100` in 1: sole clock.
- `rst_100` in 1: reset; synchronous, active-high.
- `restart` in 1: single-cycle request to rerun the sequence from the start.
- `sdram_init_done` in 1: level from the SDRAM controller.
- `cam_cfg_done` in 1: level from the SCCB configurator.
- `sdram_rst` out 1: active-high reset to the SDRAM controller.
- `cam_pwdn` out 1: camera power-down, active-high.
- `cam_cfg_start` out 1: one-cycle pulse starting camera configuration.
- `video_en` out 1: enables the capture and VGA path.
- `seq_busy` out 1: high in every state except `RUN` and `FAULT`.
- `seq_fault` out 1: high in `FAULT`.
- `retry_cnt` out 2: number of timeouts since the last reset or restart.

## Operation
- FSM states: `RESET_HOLD`, `SDRAM_WAIT`, `CAM_PWR`, `CAM_CFG`, `SETTLE`, `RUN`, `FAULT`.
- `RESET_HOLD`
  - Outputs: `sdram_rst`=1, `cam_pwdn`=1, `video_en`=0.
  - Leaves to `SDRAM_WAIT` after exactly `SETTLE_CYC` cycles.
- `SDRAM_WAIT`
  - Outputs: `sdram_rst`=0.
  - Goes to `CAM_PWR` on the first sampled `sdram_init_done`=1.
- `CAM_PWR`
  - Outputs: `cam_pwdn`=0.
  - After `CAM_PWDN_CYC` cycles goes to `CAM_CFG`.
  - `cam_cfg_start` pulses on the first cycle of `CAM_CFG`.
- `CAM_CFG`: goes to `SETTLE` on the first sampled `cam_cfg_done`=1.
- `SETTLE`: goes to `RUN` after `SETTLE_CYC` cycles.
- `RUN`: `video_en`=1; stays indefinitely.
- `cam_cfg_done` is sampled only in `CAM_CFG`. A stale high level seen in earlier states is ignored.
- Loss of `sdram_init_done` in `CAM_PWR`, `CAM_CFG`, `SETTLE` or `RUN`:
  - Goes to `RESET_HOLD`.
  - `retry_cnt` is not incremented.
- `restart` in any state:
  - Goes to `RESET_HOLD` and clears `retry_cnt`.
  - Has priority over every other transition in the same cycle.
- `FAULT`: all outputs at their reset values except `seq_fault`=1 and `seq_busy`=0. It exits only on `restart` or `rst_100`.
- Counter:
  - One shared `CNT_W`-bit down-counter.
  - Loaded on every state entry; it does not wrap.
  - Zero is detected one load-value after entry.

## Timing
- All outputs are registered, Moore-style, and decoded from the next state. Each output changes on the same edge as the state register.
- Reset values: state=`RESET_HOLD`, `sdram_rst`=1, `cam_pwdn`=1, `cam_cfg_start`=0, `video_en`=0, `seq_busy`=1, `seq_fault`=0, `retry_cnt`=0.
- `rst_100` asserted mid-sequence returns all of the above on the next edge.
- Latency from `rst_100` deassertion to `sdram_rst` falling is `SETTLE_CYC` cycles.
- Latency from an input done-level to the state change is 1 cycle.
- `cam_cfg_start` is exactly 1 cycle wide. It is re-issued on every entry to `CAM_CFG`.

## Configuration
- `BRINGUP_TIMEOUT_EN` defined:
  - The watchdog runs in `SDRAM_WAIT` and `CAM_CFG`.
  - At `TIMEOUT_CYC` cycles, `retry_cnt` increments and the FSM goes to `RESET_HOLD`.
  - If the incremented value equals `MAX_RETRY`, the FSM goes to `FAULT` instead.
- `BRINGUP_TIMEOUT_EN` undefined:
  - Both wait states wait indefinitely.
  - `FAULT` is unreachable.
  - `seq_fault` and `retry_cnt` are tied to 0.

## Structure
- `bringup_pkg` holds:
  - the state enum and its encoding;
  - the `RETRY_W`=2 constant;
  - localparams for the default cycle counts.
- Sub-module `seq_timer`: load/decrement counter with a zero flag, parameterised by `CNT_W`.

## Test plan
Common setup: `SETTLE_CYC`=4, `CAM_PWDN_CYC`=8, `TIMEOUT_CYC`=16, `MAX_RETRY`=2.
- Nominal:
  - Stimulus: release `rst_100`; raise `sdram_init_done` at cycle 10; raise `cam_cfg_done` 5 cycles after the start pulse.
  - Response: `sdram_rst` falls at cycle 4; `cam_cfg_start` pulses once 8 cycles after `cam_pwdn` falls; `video_en` rises 4 cycles after `cam_cfg_done` is sampled; `seq_busy`=0 from then on.
- SDRAM hang with macro defined:
  - Stimulus: hold `sdram_init_done`=0.
  - Response: two timeouts of 16 cycles each; `retry_cnt` goes 1 then 2; `seq_fault`=1; `sdram_rst`=1.
- Stale done:
  - Stimulus: `cam_cfg_done`=1 from reset onwards.
  - Response: no skip before `CAM_CFG`; `SETTLE` is entered 1 cycle after `CAM_CFG` entry.
- SDRAM loss in `RUN`:
  - Stimulus: drop `sdram_init_done` for 1 cycle.
  - Response: `video_en` falls and `sdram_rst` rises on the next edge; `retry_cnt` unchanged.
- Restart collision:
  - Stimulus: `restart` and `cam_cfg_done` in the same cycle.
  - Response: `RESET_HOLD` is entered; `retry_cnt`=0; `restart` from `FAULT` reruns the full nominal sequence.
- Mid-sequence reset:
  - Stimulus: `rst_100` pulsed during `CAM_PWR`.
  - Response: all outputs show their reset values on the following edge.
